// File: rtl/bcd_scan_controller.sv
// bcd_scan_controller: scans a captured NDIG-digit BCD word MS-first onto a shared decoder with blanking and error flags
module bcd_scan_controller #(
  parameter int NDIG  = 4,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_word,
  input  logic              blank,
  output logic [3:0]        bcd_out,
  output logic [NDIG-1:0]   dig_sel,
  output logic              dig_valid,
  output logic              busy,
  output logic              done,
  output logic [NDIG-1:0]   err_mask,
  output logic              err
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, n_state;
  logic [4*NDIG-1:0] word, n_word;
  logic [NDIG-1:0] vm, n_vm, n_mask, n_sel;
  logic [IW-1:0] idx, n_idx;
  logic [CW-1:0] cnt, n_cnt;
  logic [3:0] n_bcd;
  logic n_valid, last;
  function automatic logic [NDIG-1:0] bad(input logic [4*NDIG-1:0] w);
    for (int i = 0; i < NDIG; i++) bad[i] = w[4*i +: 4] > 4'd9;
  endfunction
  // a digit is shown when it is decimal and not part of the leading-zero run (digit 0 always counts)
  function automatic logic [NDIG-1:0] shown(input logic [4*NDIG-1:0] w, input logic b);
    logic z;
    z = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      z = z & (w[4*i +: 4] == 4'd0);
      shown[i] = (w[4*i +: 4] <= 4'd9) && !(b && z && i != 0);
    end
  endfunction
  assign last = cnt == CW'(DWELL - 1);
  always_comb begin
    n_state = state;
    n_word  = word;
    n_vm    = vm;
    n_mask  = err_mask;
    n_idx   = idx;
    n_cnt   = cnt;
    case (state)
      IDLE: if (start) begin
        n_state = SCAN;
        n_word  = bcd_word;
        n_vm    = shown(bcd_word, blank);
        n_mask  = bad(bcd_word);
        n_idx   = IW'(NDIG - 1);
        n_cnt   = '0;
      end
      SCAN: begin
        n_cnt   = last ? '0 : cnt + 1'b1;
        n_idx   = last && idx != '0 ? idx - 1'b1 : idx;
        n_state = last && idx == '0 ? DONE : SCAN;
      end
      default: n_state = IDLE;
    endcase
    n_bcd   = n_state == SCAN ? n_word[4*n_idx +: 4] : 4'd0;
    n_sel   = n_state == SCAN ? NDIG'(1) << n_idx : '0;
    n_valid = n_state == SCAN ? n_vm[n_idx] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      vm        <= '0;
      idx       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      dig_sel   <= '0;
      dig_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_mask  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= n_state;
      word      <= n_word;
      vm        <= n_vm;
      idx       <= n_idx;
      cnt       <= n_cnt;
      bcd_out   <= n_bcd;
      dig_sel   <= n_sel;
      dig_valid <= n_valid;
      busy      <= n_state == SCAN;
      done      <= n_state == DONE;
      err_mask  <= n_mask;
      err       <= |n_mask;
    end
  end
endmodule

// File: tb/tb_bcd_scan_controller.sv
// tb_bcd_scan_controller: table vectors, hand sequences and random traffic against a frame-timeline model
module tb_bcd_scan_controller;
  localparam int N = 4, D = 4;
  logic clk = 1'b0, rst, start, blank, dig_valid, busy, done, err;
  logic [15:0] bcd_word;
  logic [3:0] bcd_out, dig_sel, err_mask;
  int checks = 0, errors = 0, p = 0, cyc = 0, last_done = -1;
  logic [15:0] mw = '0;
  logic mb = 1'b0;
  logic [3:0] mmask = '0, vs;
  typedef struct {logic [15:0] w; logic b; logic [3:0] v; logic [3:0] m;} vec_t;
  vec_t tv[7];
  always #5 clk = ~clk;
  bcd_scan_controller #(.NDIG(N), .DWELL(D)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_word(bcd_word), .blank(blank),
    .bcd_out(bcd_out), .dig_sel(dig_sel), .dig_valid(dig_valid), .busy(busy),
    .done(done), .err_mask(err_mask), .err(err)
  );
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
    end
  endtask
  // p counts cycles since the accepted start: 1..N*D scanning, N*D+1 done pulse, 0 idle
  task automatic step(input logic s, input logic [15:0] w, input logic b, input logic r, input string name);
    int ix;
    logic [3:0] d, sel;
    logic v, bu, dn;
    start = s; bcd_word = w; blank = b; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      p = 0;
      mmask = '0;
    end else if (p == 0) begin
      if (s) begin
        p = 1; mw = w; mb = b;
        for (int i = 0; i < N; i++) mmask[i] = ((w >> (4 * i)) & 16'hF) > 9;
      end
    end else p = p == N * D + 1 ? 0 : p + 1;
    d = '0; sel = '0; v = 1'b0; bu = 1'b0;
    if (p >= 1 && p <= N * D) begin
      ix  = N - 1 - (p - 1) / D;
      d   = 4'((mw >> (4 * ix)) & 16'hF);
      sel = 4'(1 << ix);
      v   = d < 10 && !(mb && ix != 0 && (mw >> (4 * ix)) == 0);
      bu  = 1'b1;
    end
    dn = p == N * D + 1;
    #1;
    check(name, {bcd_out, dig_sel, dig_valid, busy, done, err_mask, err}, {d, sel, v, bu, dn, mmask, |mmask});
    if (done) begin
      if (last_done >= 0 && s && name == "b2b") check("period", 16'(cyc - last_done), 16'd18);
      last_done = cyc;
    end
  endtask
  initial begin
    tv[0] = '{16'h1234, 1'b0, 4'b1111, 4'b0000};
    tv[1] = '{16'h0047, 1'b1, 4'b0011, 4'b0000};
    tv[2] = '{16'h0000, 1'b1, 4'b0001, 4'b0000};
    tv[3] = '{16'h0A05, 1'b1, 4'b0011, 4'b0100};
    tv[4] = '{16'h12F4, 1'b0, 4'b1101, 4'b0010};
    tv[5] = '{16'h1111, 1'b0, 4'b1111, 4'b0000};
    tv[6] = '{16'h0047, 1'b0, 4'b1111, 4'b0000};
    step(1'b1, 16'h1234, 1'b1, 1'b1, "reset");
    step(1'b0, 16'h0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "idle");
    for (int i = 0; i < 7; i++) begin
      vs = '0;
      step(1'b1, tv[i].w, tv[i].b, 1'b0, "tbl_start");
      vs[3] = dig_valid;
      check("tbl_mask", {12'b0, err_mask}, {12'b0, tv[i].m});
      check("tbl_err", {15'b0, err}, {15'b0, tv[i].m != 0});
      for (int j = 1; j <= N * D; j++) begin
        step(1'b0, 16'($urandom), 1'($urandom), 1'b0, "tbl_scan");
        if (j % D == 0 && j < N * D) vs[3 - j / D] = dig_valid;
      end
      check("tbl_valid", {12'b0, vs}, {12'b0, tv[i].v});
      step(1'b0, 16'h0, 1'b0, 1'b0, "tbl_idle");
    end
    step(1'b1, 16'h1234, 1'b0, 1'b0, "midstart");
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "midstart");
    step(1'b1, 16'h9999, 1'b1, 1'b0, "midstart");
    for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "midstart");
    last_done = -1;
    for (int i = 0; i < 60; i++) step(1'b1, 16'h0305, 1'b1, 1'b0, "b2b");
    step(1'b0, 16'h0, 1'b0, 1'b0, "b2b_end");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "b2b_end");
    step(1'b1, 16'h5678, 1'b0, 1'b0, "abort");
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "abort");
    step(1'b1, 16'h0, 1'b0, 1'b1, "abort_rst");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "abort_idle");
    step(1'b1, 16'h9081, 1'b1, 1'b0, "after_abort");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0, 1'b0, "after_abort");
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom), $urandom_range(0, 60) == 0, "random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_scan_controller.md
# bcd_scan_controller

Multi-digit scan controller for the shared BCD-to-decimal decoder in the DD lab datapath. It captures a packed NDIG-digit BCD word on a start handshake. It then presents the digits one at a time, most significant first, to the single decoder's 4-bit input, driving a one-hot digit select and a per-digit valid. It also performs leading-zero blanking and flags non-BCD digits (values 10–15). A one-cycle Done pulse marks the end of each frame.

## Interface
- NDIG, 4: number of BCD digits per frame (≥2).
- DWELL, 4: cycles each digit is held on the decoder (≥1).

- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  frame request; sampled only in IDLE.
- BCDWord  in  4*NDIG  packed digits; [4*NDIG-1:4*NDIG-4] is the most significant digit.
- Blank  in  1  leading-zero blanking enable; captured with BCDWord.
- BCDOut  out  4  digit value driven to the shared decoder's BCDIn.
- DigSel  out  NDIG  one-hot select of the digit currently on BCDOut; bit NDIG-1 is the MS digit.
- DigValid  out  1  current digit should be displayed (not blanked, not invalid).
- Busy  out  1  frame scan in progress.
- Done  out  1  one-cycle end-of-frame pulse.
- ErrMask  out  NDIG  bit i = captured digit i > 9.
- Err  out  1  OR of ErrMask.

## Operation
- States: IDLE, SCAN, DONE. RST forces IDLE from any state, including mid-scan, with all outputs 0.
- Reset and IDLE output values: BCDOut=0, DigSel=0, DigValid=0, Busy=0, Done=0. ErrMask and Err are 0 after reset; otherwise they hold their last frame's value in IDLE.
- IDLE: on Start=1, register BCDWord and Blank. Compute ErrMask from the captured word, which replaces any previous value. Load digit index NDIG-1 and dwell counter 0. Go to SCAN.
- SCAN:
  - BCDOut = captured digit[index]; DigSel = 1<<index; Busy=1.
  - The dwell counter increments each cycle. When it reaches DWELL-1, it clears and the index decrements.
  - After the DWELL-th cycle of index 0, go to DONE.
- DONE: Done=1, Busy=0, DigSel=0, BCDOut=0 for exactly one cycle, then IDLE. Start is ignored in DONE.
- Start is ignored while in SCAN. The captured word and Blank are stable for the whole frame; changes to BCDWord or Blank mid-frame have no effect.
- Invalid digit (>9): BCDOut still carries the raw value. DigValid=0 for that digit.
- Blanking, when the captured Blank=1:
  - A digit is blanked (DigValid=0) if it and every more-significant digit equal 0.
  - Digit 0 is never blanked.
  - An invalid digit counts as nonzero and ends the blanking run.
- DigValid = not invalid AND not blanked. Its value is determined for the whole dwell of a digit.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Start sampled high in IDLE at edge t.
- From t+1, SCAN begins: Busy=1, DigSel=MS bit, and ErrMask/Err are valid.
- Digit k (counting from the MS digit, k=0) occupies cycles t+1+k*DWELL through t+(k+1)*DWELL.
- Done=1 in cycle t+1+NDIG*DWELL. The machine is back in IDLE the cycle after.
- Frame period with Start held high: NDIG*DWELL+2 cycles, i.e. 18 for the defaults.
- DWELL=1: each digit is held one cycle, and DigSel changes every cycle.
- RST high during SCAN: outputs are 0 on the next cycle. No Done pulse is emitted for the aborted frame.
- RST and Start high together: RST wins.

## Test plan
- Reset: RST high for 2 cycles, then Start=0 -> all outputs 0; stays IDLE.
- Basic frame, BCDWord=16'h1234, Blank=0, defaults:
  - BCDOut sequence 1,2,3,4, each held 4 cycles.
  - DigSel sequence 1000, 0100, 0010, 0001.
  - DigValid=1 throughout; Done in cycle t+17; ErrMask=0000.
- Blanking, Blank=1:
  - 16'h0047 -> DigValid 0,0,1,1.
  - 16'h0000 -> DigValid 0,0,0,1.
  - 16'h0A05 -> DigValid 0,0,1,1, ErrMask=0100, Err=1; DigValid=0 for the A digit as well.
- Error: 16'h12F4, Blank=0 -> BCDOut shows F for digit 1 with DigValid=0, ErrMask=0010, Err=1. A following Start with 16'h1111 clears Err from t+1.
- Handshake: Start held high continuously -> back-to-back frames with 18-cycle period. A Start pulse mid-SCAN with a different BCDWord leaves the frame unaffected.
- Abort: RST asserted at cycle t+6 of a frame -> outputs 0 from t+7, no Done. A later Start runs a full frame normally.
